// File: rtl/restaura_pc_preemp_pkg.sv
// Shared definitions for the preemption save / restore / scheduler slice.
package restaura_pc_preemp_pkg;

  localparam int unsigned NUM_PROC_DEF = 8;
  localparam int unsigned ID_W_DEF     = $clog2(NUM_PROC_DEF);
  localparam int unsigned PC_W         = 32;

  // Restore sequence states; encoding shared with the scheduler.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LOAD = 2'd2
  } rest_state_e;

endpackage

// File: rtl/restaura_pc_preemp_tabela.sv
// pc_ctx_tabela: saved-PC register file (1 write / 1 read) with per-slot
// valid bits, save/clear ports and same-cycle write-to-read bypass.
module pc_ctx_tabela
  import restaura_pc_preemp_pkg::*;
#(
  parameter int unsigned NUM_PROC = NUM_PROC_DEF,
  parameter int unsigned ID_W     = $clog2(NUM_PROC)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                save_en,
  input  logic [ID_W-1:0]     save_id,
  input  logic [PC_W-1:0]     saved_pc,
  input  logic                clear_en,
  input  logic [ID_W-1:0]     clear_id,
  input  logic [ID_W-1:0]     rd_id,
  input  logic [PC_W-1:0]     rd_dflt,
  output logic [PC_W-1:0]     rd_pc,
  output logic [NUM_PROC-1:0] slot_valid
);

  logic [PC_W-1:0]     tbl_q [NUM_PROC];
  logic [PC_W-1:0]     tbl_d [NUM_PROC];
  logic [NUM_PROC-1:0] valid_q;
  logic [NUM_PROC-1:0] valid_d;

  // Next table/valid state; save is applied after clear so it wins.
  always_comb begin
    tbl_d   = tbl_q;
    valid_d = valid_q;
    if (clear_en) valid_d[clear_id] = 1'b0;
    if (save_en) begin
      tbl_d[save_id]   = saved_pc;
      valid_d[save_id] = 1'b1;
    end
  end

  // Reading the next-state view gives the same-cycle save/clear bypass.
  always_comb begin
    rd_pc = valid_d[rd_id] ? tbl_d[rd_id] : rd_dflt;
  end

  // Table storage; contents after reset are don't-care.
  always_ff @(posedge clk) begin
    tbl_q <= tbl_d;
  end

  // Valid bits, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  assign slot_valid = valid_q;

endmodule

// File: rtl/restaura_pc_preemp.sv
// Context-restore unit: returns a process's saved PC (or its start address)
// to the PC-select path through an IDLE -> READ -> LOAD sequence.
module restaura_pc_preemp
  import restaura_pc_preemp_pkg::*;
#(
  parameter int unsigned NUM_PROC = NUM_PROC_DEF,
  parameter int unsigned ID_W     = $clog2(NUM_PROC)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                save_en,
  input  logic [ID_W-1:0]     save_id,
  input  logic [31:0]         saved_pc,
  input  logic                clear_en,
  input  logic [ID_W-1:0]     clear_id,
  input  logic                resume_req,
  input  logic [ID_W-1:0]     resume_id,
  input  logic [31:0]         pc_start,
  output logic                busy,
  output logic                pc_load,
  output logic [31:0]         pc_restore,
  output logic [NUM_PROC-1:0] slot_valid
);

  rest_state_e     state_q, state_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [PC_W-1:0] start_q, start_d;
  logic            busy_q, busy_d;
  logic            pc_load_q, pc_load_d;
  logic [PC_W-1:0] pc_restore_q, pc_restore_d;
  logic [PC_W-1:0] rd_pc;

  pc_ctx_tabela #(
    .NUM_PROC (NUM_PROC),
    .ID_W     (ID_W)
  ) u_tabela (
    .clk        (clk),
    .reset      (reset),
    .save_en    (save_en),
    .save_id    (save_id),
    .saved_pc   (saved_pc),
    .clear_en   (clear_en),
    .clear_id   (clear_id),
    .rd_id      (id_q),
    .rd_dflt    (start_q),
    .rd_pc      (rd_pc),
    .slot_valid (slot_valid)
  );

  // Next-state and next-output logic; outputs are computed one state ahead
  // so busy/pc_load/pc_restore can be plain registers.
  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    start_d      = start_q;
    busy_d       = 1'b0;
    pc_load_d    = 1'b0;
    pc_restore_d = '0;
    unique case (state_q)
      IDLE: begin
        if (resume_req) begin
          state_d = READ;
          id_d    = resume_id;
          start_d = pc_start;
          busy_d  = 1'b1;
        end
      end
      READ: begin
        state_d      = LOAD;
        busy_d       = 1'b1;
        pc_load_d    = 1'b1;
        pc_restore_d = rd_pc;
      end
      LOAD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and registered outputs; reset aborts any sequence in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      id_q         <= '0;
      start_q      <= '0;
      busy_q       <= 1'b0;
      pc_load_q    <= 1'b0;
      pc_restore_q <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      pc_load_q    <= pc_load_d;
      pc_restore_q <= pc_restore_d;
    end
  end

  assign busy       = busy_q;
  assign pc_load    = pc_load_q;
  assign pc_restore = pc_restore_q;

endmodule

// File: tb/tb_restaura_pc_preemp.sv
// Bench for restaura_pc_preemp: directed vector table, a mid-LOAD save
// sequence and randomized traffic against a slot/timestamp reference model.
module tb_restaura_pc_preemp;

  localparam int unsigned NP = 8;
  localparam int unsigned IW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          save_en;
  logic [IW-1:0] save_id;
  logic [31:0]   saved_pc;
  logic          clear_en;
  logic [IW-1:0] clear_id;
  logic          resume_req;
  logic [IW-1:0] resume_id;
  logic [31:0]   pc_start;
  logic          busy;
  logic          pc_load;
  logic [31:0]   pc_restore;
  logic [NP-1:0] slot_valid;

  restaura_pc_preemp #(
    .NUM_PROC (NP),
    .ID_W     (IW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .save_en    (save_en),
    .save_id    (save_id),
    .saved_pc   (saved_pc),
    .clear_en   (clear_en),
    .clear_id   (clear_id),
    .resume_req (resume_req),
    .resume_id  (resume_id),
    .pc_start   (pc_start),
    .busy       (busy),
    .pc_load    (pc_load),
    .pc_restore (pc_restore),
    .slot_valid (slot_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: slot contents plus the edge index of the last accepted
  // request. A request is served over the two edges that follow it.
  logic [31:0]   m_tbl [NP];
  logic [NP-1:0] m_valid = '0;
  bit            m_active = 1'b0;
  longint        m_acc = 0;
  longint        ecount = 0;
  logic [IW-1:0] m_id = '0;
  logic [31:0]   m_start = '0;
  logic [31:0]   m_sel = '0;

  typedef struct {
    bit          rst;
    bit          se;
    logic [2:0]  sid;
    logic [31:0] spc;
    bit          ce;
    logic [2:0]  cid;
    bit          rq;
    logic [2:0]  rid;
    logic [31:0] pst;
    bit          eb;
    bit          el;
    logic [31:0] er;
    logic [7:0]  ev;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(bit rst, bit se, logic [2:0] sid, logic [31:0] spc,
                              bit ce, logic [2:0] cid, bit rq, logic [2:0] rid,
                              logic [31:0] pst, bit eb, bit el, logic [31:0] er,
                              logic [7:0] ev);
    vec_t v;
    v.rst = rst; v.se = se; v.sid = sid; v.spc = spc; v.ce = ce; v.cid = cid;
    v.rq = rq; v.rid = rid; v.pst = pst; v.eb = eb; v.el = el; v.er = er; v.ev = ev;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @edge %0d: got %h want %h", nm, ecount, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; save_en = v.se; save_id = v.sid; saved_pc = v.spc;
    clear_en = v.ce; clear_id = v.cid; resume_req = v.rq; resume_id = v.rid;
    pc_start = v.pst;
  endtask

  // One clock edge: update the model from the applied inputs, then compare.
  task automatic cyc();
    bit acc;
    bit e_busy, e_load;
    @(posedge clk);
    ecount++;
    if (reset) begin
      m_valid  = '0;
      m_active = 1'b0;
    end else begin
      acc = resume_req && (!m_active || ecount >= m_acc + 3);
      if (clear_en) m_valid[clear_id] = 1'b0;
      if (save_en) begin
        m_tbl[save_id]   = saved_pc;
        m_valid[save_id] = 1'b1;
      end
      if (m_active && ecount == m_acc + 1)
        m_sel = m_valid[m_id] ? m_tbl[m_id] : m_start;
      if (acc) begin
        m_active = 1'b1;
        m_acc    = ecount;
        m_id     = resume_id;
        m_start  = pc_start;
      end
    end
    #1;
    e_busy = m_active && (ecount - m_acc) <= 1;
    e_load = m_active && (ecount - m_acc) == 1;
    chk("model_busy", {31'd0, busy}, {31'd0, e_busy});
    chk("model_pc_load", {31'd0, pc_load}, {31'd0, e_load});
    chk("model_pc_restore", pc_restore, e_load ? m_sel : 32'd0);
    chk("model_slot_valid", {24'd0, slot_valid}, {24'd0, m_valid});
  endtask

  initial begin
    vec_t v;
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // rst se sid spc        ce cid rq rid pst         busy load restore valid
    tv.push_back(mk(1, 0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    8'h00));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 0, 1, 3, 32'h100,  1, 0, 32'h0,    8'h00));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    1, 1, 32'h100,  8'h00));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    8'h00));
    tv.push_back(mk(0, 1, 5, 32'h42,   0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    8'h20));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 0, 1, 5, 32'h999,  1, 0, 32'h0,    8'h20));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    1, 1, 32'h42,   8'h20));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    8'h20));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 0, 1, 2, 32'h5,    1, 0, 32'h0,    8'h20));
    tv.push_back(mk(0, 1, 2, 32'h77,   0, 0, 0, 0, 32'h0,    1, 1, 32'h77,   8'h24));
    tv.push_back(mk(0, 1, 2, 32'h88,   0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    8'h24));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 0, 1, 2, 32'h0,    1, 0, 32'h0,    8'h24));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    1, 1, 32'h88,   8'h24));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    8'h24));
    tv.push_back(mk(0, 1, 1, 32'h20,   0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    8'h26));
    tv.push_back(mk(0, 0, 0, 32'h0,    1, 1, 0, 0, 32'h0,    0, 0, 32'h0,    8'h24));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 0, 1, 1, 32'h0,    1, 0, 32'h0,    8'h24));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    1, 1, 32'h0,    8'h24));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    8'h24));
    tv.push_back(mk(0, 1, 1, 32'h21,   1, 1, 0, 0, 32'h0,    0, 0, 32'h0,    8'h26));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 0, 1, 1, 32'hdead, 1, 0, 32'h0,    8'h26));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    1, 1, 32'h21,   8'h26));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    8'h26));
    tv.push_back(mk(0, 1, 4, 32'h10,   0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    8'h36));
    tv.push_back(mk(0, 1, 6, 32'h30,   0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    8'h76));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 0, 1, 4, 32'h0,    1, 0, 32'h0,    8'h76));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 0, 1, 6, 32'h0,    1, 1, 32'h10,   8'h76));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 0, 1, 6, 32'h0,    0, 0, 32'h0,    8'h76));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 0, 1, 6, 32'h0,    1, 0, 32'h0,    8'h76));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 0, 1, 6, 32'h0,    1, 1, 32'h30,   8'h76));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    8'h76));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 0, 1, 3, 32'h55,   1, 0, 32'h0,    8'h76));
    tv.push_back(mk(1, 0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    8'h00));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    8'h00));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    0, 0, 32'h0,    8'h00));

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i]);
      cyc();
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, tv[i].eb});
      chk($sformatf("vec%0d_pc_load", i), {31'd0, pc_load}, {31'd0, tv[i].el});
      chk($sformatf("vec%0d_pc_restore", i), pc_restore, tv[i].er);
      chk($sformatf("vec%0d_slot_valid", i), {24'd0, slot_valid}, {24'd0, tv[i].ev});
    end

    // Save arriving during LOAD must not disturb the value being strobed.
    drive(mk(0, 1, 7, 32'hAAAA, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc();
    drive(mk(0, 0, 0, 32'h0, 0, 0, 1, 7, 32'h0, 0, 0, 0, 0));
    cyc();
    drive(mk(0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0));
    cyc();
    chk("load_strobe", pc_restore, 32'hAAAA);
    drive(mk(0, 1, 7, 32'hBBBB, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #3;
    chk("load_hold_pc", pc_restore, 32'hAAAA);
    chk("load_hold_strobe", {31'd0, pc_load}, 32'd1);
    cyc();
    drive(mk(0, 0, 0, 32'h0, 0, 0, 1, 7, 32'h1, 0, 0, 0, 0));
    cyc();
    drive(mk(0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0));
    cyc();
    chk("load_save_landed", pc_restore, 32'hBBBB);
    cyc();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      v.rst = ($urandom_range(0, 63) == 0);
      v.se  = ($urandom_range(0, 2) == 0);
      v.sid = 3'($urandom_range(0, NP - 1));
      v.spc = $urandom;
      v.ce  = ($urandom_range(0, 3) == 0);
      v.cid = 3'($urandom_range(0, NP - 1));
      v.rq  = ($urandom_range(0, 1) == 0);
      v.rid = 3'($urandom_range(0, NP - 1));
      v.pst = $urandom;
      drive(v);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
